// File: rtl/fp_add_sequencer_pkg.sv
// fp_add_sequencer_pkg: float classification and sequencer types shared by the adder front end
package fp_add_sequencer_pkg;
    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, OUTPUT} seq_state_t;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [7:0] EXP_MAX = 8'hFF;
    // Denormals classify as zero: the adder path is flush-to-zero.
    function automatic fp_class_t fp_classify(logic [31:0] f);
        return f[30:23] == 8'h00 ? FP_ZERO
             : f[30:23] != EXP_MAX ? FP_NORM
             : f[22:0] != 23'h0 ? FP_NAN
             : FP_INF;
    endfunction
endpackage

// File: rtl/fp_add_sequencer_special_case.sv
// fp_add_sequencer_special_case: resolves operand pairs whose sum is known without the adder
module fp_add_sequencer_special_case #(
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        IsBypass,
    output logic [31:0] Result,
    output logic        Zero,
    output logic        Inf,
    output logic        Nan
);
    import fp_add_sequencer_pkg::*;
    fp_class_t classA, classB, resClass;
    logic cancels;
    assign classA = fp_classify(A);
    assign classB = fp_classify(B);
    assign cancels = A[30:0] == B[30:0] && A[31] != B[31];
    always_comb begin
        IsBypass = classA != FP_NORM || classB != FP_NORM || cancels;
        Result = (classA == FP_NAN || classB == FP_NAN) ? CANON_NAN
               : (classA == FP_INF && classB == FP_INF && A[31] != B[31]) ? CANON_NAN
               : classA == FP_INF ? A
               : classB == FP_INF ? B
               : (classA == FP_ZERO && classB == FP_ZERO) ? {A[31] & B[31], 31'h0}
               : classA == FP_ZERO ? B
               : classB == FP_ZERO ? A
               : POS_ZERO;
    end
    assign resClass = fp_classify(Result);
    assign Zero = IsBypass && resClass == FP_ZERO;
    assign Inf = IsBypass && resClass == FP_INF;
    assign Nan = IsBypass && resClass == FP_NAN;
endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: issue/retire stage ahead of FloatingPointAdder with local special-case bypass
module fp_add_sequencer #(
    parameter int          FIFO_DEPTH = 2,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] InA,
    input  logic [31:0] InB,
    output logic [31:0] AddendA,
    output logic [31:0] AddendB,
    output logic        Go,
    input  logic [31:0] AdderResult,
    input  logic        AdderDone,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Result,
    output logic        Zero,
    output logic        Inf,
    output logic        Nan,
    output logic        Timeout,
    output logic        Busy
);
    import fp_add_sequencer_pkg::*;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    seq_state_t state, nextState;
    logic [31:0] memA [FIFO_DEPTH];
    logic [31:0] memB [FIFO_DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [PW:0] count;
    logic [TW-1:0] timer;
    logic [31:0] opA, opB, resReg, bypResult, cleanResult;
    logic zeroReg, infReg, nanReg, timeoutReg;
    logic push, pop, timerExpired, bypass, bypZero, bypInf, bypNan, cleanZero, cleanInf;

    assign push = InValid && InReady;
    assign pop = state == IDLE && count != '0;
    assign timerExpired = timer == TW'(TIMEOUT_CYCLES - 1);

    // The FIFO head is classified while still in IDLE so a bypass result is ready one cycle after the pop.
    fp_add_sequencer_special_case #(.CANON_NAN(CANON_NAN)) specialCase (
        .A(memA[rdPtr]),
        .B(memB[rdPtr]),
        .IsBypass(bypass),
        .Result(bypResult),
        .Zero(bypZero),
        .Inf(bypInf),
        .Nan(bypNan)
    );

    assign cleanInf = AdderResult[30:23] == EXP_MAX;
    assign cleanZero = AdderResult[30:23] == 8'h00;
    assign cleanResult = cleanInf ? {AdderResult[31], EXP_MAX, 23'h0}
                       : cleanZero ? {AdderResult[31], 31'h0}
                       : AdderResult;

    always_ff @(posedge Clock) begin
        if (push) begin
            memA[wrPtr] <= InA;
            memB[wrPtr] <= InB;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop) rdPtr <= rdPtr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            opA <= '0;
            opB <= '0;
            resReg <= '0;
            {zeroReg, infReg, nanReg, timeoutReg} <= '0;
            timer <= '0;
        end else begin
            timer <= state == WAIT ? timer + TW'(1) : '0;
            if (pop) begin
                opA <= memA[rdPtr];
                opB <= memB[rdPtr];
            end
            if (pop && bypass)
                {resReg, zeroReg, infReg, nanReg, timeoutReg} <= {bypResult, bypZero, bypInf, bypNan, 1'b0};
            else if (state == WAIT && AdderDone)
                {resReg, zeroReg, infReg, nanReg, timeoutReg} <= {cleanResult, cleanZero, cleanInf, 2'b00};
            else if (state == WAIT && timerExpired)
                {resReg, zeroReg, infReg, nanReg, timeoutReg} <= {CANON_NAN, 4'b0011};
        end
    end

    always_ff @(posedge Clock) begin
        state <= Reset ? IDLE : nextState;
    end

    // AdderDone is checked before the timer, so a completion on the last WAIT cycle still wins.
    always_comb begin
        nextState = state == IDLE ? (pop ? (bypass ? OUTPUT : LAUNCH) : IDLE)
                  : state == LAUNCH ? WAIT
                  : state == WAIT ? ((AdderDone || timerExpired) ? OUTPUT : WAIT)
                  : (OutReady ? IDLE : OUTPUT);
    end

    always_comb begin
        InReady = count != (PW+1)'(FIFO_DEPTH);
        Go = state == LAUNCH && !Reset;
        AddendA = opA;
        AddendB = opB;
        OutValid = state == OUTPUT;
        Result = resReg;
        Zero = state == OUTPUT && zeroReg;
        Inf = state == OUTPUT && infReg;
        Nan = state == OUTPUT && nanReg;
        Timeout = state == OUTPUT && timeoutReg;
        Busy = state != IDLE || count != '0;
    end
endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Issue/retire stage directly upstream of FloatingPointAdder.
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Resolves IEEE-754 single special cases locally (bypass). Otherwise launches the adder with a one-cycle Go, waits for ResultReady with a timeout, and cleans up the result before returning it downstream with Zero/Inf/Nan flags.

Parameters:
- FIFO_DEPTH, 2, operand-pair FIFO entries (power of 2, ≥2).
- TIMEOUT_CYCLES, 64, WAIT cycles before the adder is declared hung.
- CANON_NAN, 32'h7FC0_0000, NaN pattern emitted for every NaN result.

Ports:
- Clock  in  1  single clock, all state on posedge.
- Reset  in  1  synchronous, active-high.
- InValid  in  1  operand pair offered.
- InReady  out  1  FIFO not full.
- InA  in  32 (float)  addend A.
- InB  in  32 (float)  addend B.
- AddendA  out  32 (float)  to adder; stable LAUNCH through WAIT exit.
- AddendB  out  32 (float)  to adder.
- Go  out  1  one-cycle adder start pulse.
- AdderResult  in  32 (float)  adder Result.
- AdderDone  in  1  adder ResultReady, level-sampled in WAIT only.
- OutValid  out  1  result available.
- OutReady  in  1  downstream accepts.
- Result  out  32 (float)  sum.
- Zero  out  1  Result is ±0.
- Inf  out  1  Result is ±Inf.
- Nan  out  1  Result is NaN.
- Timeout  out  1  Result produced by timeout.
- Busy  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset (sync): FIFO empty, state IDLE. All outputs 0 except InReady=1. Reset mid-operation discards FIFO contents and the in-flight op. Go stays 0 in the reset cycle and the cycle after.
- FIFO: push when InValid&&InReady. Pop only in IDLE when non-empty; the head moves into the operand register. InReady = !full and is not relieved by a same-cycle pop. Pointers wrap mod FIFO_DEPTH. Occupancy counter is width clog2(FIFO_DEPTH)+1.
- Classification (flush-to-zero): exp==0 → zero (frac ignored). exp==255 && frac!=0 → NaN. exp==255 && frac==0 → Inf.
- Bypass priority, first match wins:
  1. Either operand NaN → CANON_NAN.
  2. +Inf and -Inf → CANON_NAN.
  3. Any Inf → that Inf.
  4. Both zero → -0 if both signs 1, else +0.
  5. One zero → the other operand unchanged.
  6. Equal exp and frac, opposite signs → +0.
  7. Else → adder.
- FSM states: IDLE, LAUNCH, WAIT, OUTPUT.
  - IDLE + non-empty: pop. Bypass case → OUTPUT next cycle with result registered. Adder case → LAUNCH.
  - LAUNCH: Go=1 for exactly this cycle; AddendA/B = operand register; → WAIT, timer cleared.
  - WAIT: AdderDone=1 → capture and clean AdderResult, → OUTPUT. Timer reaching TIMEOUT_CYCLES → Result=CANON_NAN, Nan=1, Timeout=1, → OUTPUT. If AdderDone and timer expiry coincide, AdderDone wins.
  - OUTPUT: OutValid=1; Result and flags held stable until OutReady. On OutReady → IDLE; OutValid drops the next cycle.
- Cleanup of adder result: exp==255 → frac forced to 0, Inf=1 (overflow). exp==0 → frac forced to 0, Zero=1 (underflow flush). Sign passed through.
- Flags are mutually exclusive and valid only with OutValid; all flags are 0 outside OUTPUT.
- Latency:
  - Bypass: pop at cycle N, OutValid at N+1.
  - Adder path: Go at N+1, OutValid one cycle after AdderDone is sampled.
  - No overlap: one op in flight; results are returned in FIFO order.
- AdderDone outside WAIT is ignored.

Decomposition:
- floatingpointpkg gains:
  - fp_class_t enum: FP_ZERO, FP_NORM, FP_INF, FP_NAN.
  - Constants: CANON_NAN, POS_ZERO, EXP_MAX=8'hFF.
  - Function fp_classify(float).
  - Sequencer state enum.
- One sub-module: fp_special_case, combinational bypass resolver. Takes two floats; returns is_bypass, result, and flags. Allows unit testing separately.

Test Plan:
- 0x3F800000 + 0x40000000, adder returns 0x40400000 after 5 cycles → Go pulses once, Result 0x40400000, flags 0, OutValid one cycle after AdderDone.
- 0x7F800000 + 0xFF800000 → no Go, Result 0x7FC00000, Nan=1, OutValid one cycle after pop. Also 0x80000000 + 0x80000000 → 0x80000000, Zero=1.
- 0x3F800000 + 0xBF800000 → bypass +0 (0x00000000), Zero=1, no Go.
- Adder never asserts AdderDone, TIMEOUT_CYCLES=8 → OutValid after 8 WAIT cycles, Result 0x7FC00000, Nan=1, Timeout=1. A subsequent op completes normally.
- Three back-to-back pushes with OutReady held 0, FIFO_DEPTH=2 → InReady drops after 2 buffered plus 1 in operand register. Results are held stable, then drain in order when OutReady=1.
- Adder returns 0x7F812345 → Result 0x7F800000, Inf=1. Reset asserted during WAIT → next cycle OutValid=0, Busy=0, InReady=1, late AdderDone ignored.
